spi_slave_port: RTL and testbench
=================================

# spi_slave_port

SPI slave endpoint that serves the far end of the link feeding `master_spimemory`. It oversamples an SPI mode-0 bus on the system clock and deserializes command frames. Write frames become a single-cycle `wr_assert` with `address`/`out_instr`, the same address/instruction/assert triple the memory master consumes. Read frames issue a `rd_req` and shift the returned word back out on `miso`.

## Interface
- `width`, 32, data word width in bits.
- `addr_width`, 8, address width in bits.

- `clk`  input  1  system clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `sclk`  input  1  SPI serial clock, asynchronous to `clk`.
- `cs`  input  1  SPI chip select, active-low, asynchronous.
- `mosi`  input  1  SPI data in, asynchronous.
- `miso`  output  1  SPI data out, registered.
- `address`  output  addr_width  latched frame address.
- `out_instr`  output  width  latched write data.
- `wr_assert`  output  1  one-cycle write strobe; `address`/`out_instr` valid while high.
- `rd_req`  output  1  one-cycle read request; `address` valid while high.
- `rd_data`  input  width  read word; sampled the cycle after `rd_req`.
- `busy`  output  1  high while a frame is in progress (state != IDLE).

## Operation
- `sclk`, `cs`, `mosi`: 2-flop synchronizers, then a 1-flop history for edge detect. Rise/fall are single-cycle pulses from the synchronized `sclk`.
- Frame, MSB first, sampled on `sclk` rising edges while `cs`=0:
  - 1 R/W bit (1 = read).
  - addr_width address bits.
  - For writes: width data bits.
- `miso` updates only on detected `sclk` falling edges.
- States:
  - IDLE: `cs` falling edge -> CMD; clear `bit_cnt`.
  - CMD: rise -> capture R/W -> ADDR.
  - ADDR: shift address on each rise. After bit addr_width, load `address` -> WDATA if write, RFETCH if read.
  - WDATA: shift data on each rise. After bit width, load `out_instr`, pulse `wr_assert` next cycle -> DONE.
  - RFETCH: pulse `rd_req` for 1 cycle; next cycle load `rd_data` into the tx shifter -> RDATA.
  - RDATA: on each fall, drive the tx MSB on `miso` and shift left. After width bits driven and the final rise -> DONE.
  - DONE: ignore all `sclk`/`mosi` activity until `cs` rises -> IDLE.
- `cs` rising in any state other than IDLE/DONE aborts the frame:
  - -> IDLE, no `wr_assert`.
  - `address`/`out_instr` keep their previous values.
  - `miso` -> 0.
- `bit_cnt` is wide enough to count to max(addr_width, width). It resets to 0 on each state change.
- Reset: all state -> IDLE.
  - `miso`, `wr_assert`, `rd_req`, `busy`: 0.
  - `address`, `out_instr`: 0.
  - Synchronizer flops: `cs`=1, `sclk`=0.
- Reset asserted mid-frame discards the frame. The bus must see `cs` fall again before a new frame is accepted.

## Timing
- Constraints: `sclk` high and low phases each ≥ 4 `clk` cycles; `cs` setup/hold to the first/last `sclk` edge ≥ 4 `clk` cycles.
- Pin edge -> internal edge pulse: 3 `clk` cycles.
- Write: `wr_assert` high exactly 1 cycle, 4 `clk` cycles after the final `sclk` rising edge at the pin.
- Read:
  - `rd_req` is high 1 cycle, 4 cycles after the last address-bit rising edge.
  - `rd_data` must be valid in the cycle after `rd_req`.
  - The first data bit appears on `miso` 3 cycles after the next `sclk` falling edge at the pin.
- `miso` is stable from its update until the next fall, so the master samples it on rises.
- `busy` rises 3 cycles after `cs` falls. It falls 3 cycles after `cs` rises, or the cycle after an abort.
- Back-to-back frames: `cs` high ≥ 4 `clk` cycles between frames.

## Test plan
- Write: frame R/W=0, addr 0x2A, data 0xDEADBEEF -> `address`=0x2A, `out_instr`=0xDEADBEEF, `wr_assert` high exactly 1 cycle, `rd_req` never high.
- Read: frame R/W=1, addr 0x05, bench returns `rd_data`=0x12345678 -> `rd_req` 1 cycle with `address`=0x05; bits sampled from `miso` on the 32 rising edges = 0x12345678.
- Abort: `cs` raised after 20 bits of a write -> no `wr_assert`, `busy`=0, `address`/`out_instr` unchanged. A following full write to 0x01/0xA5A5A5A5 completes correctly.
- Extra clocks: 45 `sclk` pulses in one write frame -> exactly one `wr_assert`, carrying the first 41 bits.
- Reset mid-read: assert `reset` during RDATA -> `miso`=0, `busy`=0, all outputs 0. The next read frame from 0x10 returns correct data.
- Back-to-back: write 0x03/0x00000001 then read 0x03 with `cs` high 4 cycles between -> one `wr_assert`, then one `rd_req` at 0x03, `miso` stream = `rd_data`.

Source files
------------

// File: rtl/spi_slave_port_if.sv
// SPI pins plus the write/read-request side shared with the memory master.
// slave modport is the endpoint, master modport is whatever drives the pins and answers reads.
interface spi_slave_port_if #(
    parameter int width      = 32,
    parameter int addr_width = 8
);
    logic                  sclk;
    logic                  cs;
    logic                  mosi;
    logic                  miso;
    logic [addr_width-1:0] address;
    logic [width-1:0]      out_instr;
    logic                  wr_assert;
    logic                  rd_req;
    logic [width-1:0]      rd_data;
    logic                  busy;

    modport slave (
        input  sclk, cs, mosi, rd_data,
        output miso, address, out_instr, wr_assert, rd_req, busy
    );

    modport master (
        output sclk, cs, mosi, rd_data,
        input  miso, address, out_instr, wr_assert, rd_req, busy
    );
endinterface

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave oversampled on clk: frames become a 1-cycle wr_assert or an rd_req plus miso stream.
// Strobes land 4 clk after the deciding sclk pin edge; no backpressure, the SPI master sets the pace.
module spi_slave_port #(
    parameter int width      = 32,
    parameter int addr_width = 8
) (
    input  logic            clk,
    input  logic            reset,
    spi_slave_port_if.slave bus
);
    localparam int MAXW = (width > addr_width) ? width : addr_width;
    localparam int CW   = $clog2(MAXW + 1);
    localparam logic [CW-1:0] ADDR_LAST  = CW'(addr_width - 1);
    localparam logic [CW-1:0] DATA_LAST  = CW'(width - 1);
    localparam logic [CW-1:0] DATA_ALL   = CW'(width);
    localparam logic [CW-1:0] FETCH_LOAD = CW'(2);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RFETCH, RDATA, DONE} state_t;

    state_t                state, state_nxt;
    logic [1:0]            sclk_sync, cs_sync, mosi_sync;
    logic                  sclk_d, cs_d;
    logic [1:0]            settle;
    logic                  armed;
    logic                  sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_bit;
    logic                  abort, cnt_en;
    logic [CW-1:0]         bit_cnt;
    logic                  rw;
    logic [addr_width-1:0] addr_sh, address_q;
    logic [width-1:0]      data_sh, tx_sh, out_q;
    logic                  wr_pend, wr_q, rd_q, miso_q;

    assign sclk_rise = sclk_sync[1] & ~sclk_d;
    assign sclk_fall = ~sclk_sync[1] & sclk_d;
    assign cs_rise   = cs_sync[1] & ~cs_d;
    // A reset with cs already low must not look like a frame start.
    assign cs_fall   = armed & ~cs_sync[1] & cs_d;
    assign mosi_bit  = mosi_sync[1];

    assign bus.miso      = miso_q;
    assign bus.address   = address_q;
    assign bus.out_instr = out_q;
    assign bus.wr_assert = wr_q;
    assign bus.rd_req    = rd_q;
    assign bus.busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_en    = 1'b0;
        case (state)
            IDLE:   if (cs_fall) state_nxt = CMD;
            CMD:    if (sclk_rise) state_nxt = ADDR;
            ADDR: begin
                cnt_en = sclk_rise;
                if (sclk_rise && bit_cnt == ADDR_LAST) state_nxt = rw ? RFETCH : WDATA;
            end
            WDATA: begin
                cnt_en = sclk_rise;
                if (sclk_rise && bit_cnt == DATA_LAST) state_nxt = DONE;
            end
            RFETCH: begin
                cnt_en = 1'b1;
                if (bit_cnt == FETCH_LOAD) state_nxt = RDATA;
            end
            RDATA: begin
                cnt_en = sclk_fall && (bit_cnt != DATA_ALL);
                if (sclk_rise && bit_cnt == DATA_ALL) state_nxt = DONE;
            end
            DONE:   if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        abort = cs_rise && (state != IDLE) && (state != DONE);
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            settle    <= 2'd0;
            armed     <= 1'b0;
            bit_cnt   <= '0;
            rw        <= 1'b0;
            addr_sh   <= '0;
            data_sh   <= '0;
            tx_sh     <= '0;
            address_q <= '0;
            out_q     <= '0;
            wr_pend   <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], bus.sclk};
            cs_sync   <= {cs_sync[0], bus.cs};
            mosi_sync <= {mosi_sync[0], bus.mosi};
            sclk_d    <= sclk_sync[1];
            cs_d      <= cs_sync[1];
            // cs_sync[1] reflects the real pin only from the third edge after reset.
            if (settle != 2'd2) settle <= settle + 2'd1;
            armed     <= armed | ((settle == 2'd2) & cs_sync[1]);
            wr_pend   <= 1'b0;
            wr_q      <= wr_pend;
            rd_q      <= 1'b0;

            if (state_nxt != state) bit_cnt <= '0;
            else if (cnt_en)        bit_cnt <= bit_cnt + 1'b1;

            case (state)
                CMD: if (sclk_rise) rw <= mosi_bit;
                ADDR: if (sclk_rise) begin
                    addr_sh <= {addr_sh[addr_width-2:0], mosi_bit};
                    if (bit_cnt == ADDR_LAST) address_q <= {addr_sh[addr_width-2:0], mosi_bit};
                end
                WDATA: if (sclk_rise) begin
                    data_sh <= {data_sh[width-2:0], mosi_bit};
                    if (bit_cnt == DATA_LAST) begin
                        out_q   <= {data_sh[width-2:0], mosi_bit};
                        wr_pend <= 1'b1;
                    end
                end
                RFETCH: begin
                    if (bit_cnt == '0)        rd_q  <= 1'b1;
                    if (bit_cnt == FETCH_LOAD) tx_sh <= bus.rd_data;
                end
                RDATA: if (sclk_fall && bit_cnt != DATA_ALL) begin
                    miso_q <= tx_sh[width-1];
                    tx_sh  <= {tx_sh[width-2:0], 1'b0};
                end
                default: ;
            endcase

            if (abort) miso_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_slave_port.sv
// Drives randomized SPI mode-0 frames and scores strobes, timing and the miso stream against a frame-level model.
`timescale 1ns/1ps
module tb_spi_slave_port;
    localparam int W     = 32;
    localparam int AW    = 8;
    localparam int NBITS = 1 + AW + W;
    localparam int CLK_P = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #(CLK_P/2) clk = ~clk;

    spi_slave_port_if #(.width(W), .addr_width(AW)) bus ();
    spi_slave_port #(.width(W), .addr_width(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observed strobes, collected every cycle away from the active edge.
    logic [AW-1:0] wr_addr_q[$];
    logic [W-1:0]  wr_data_q[$];
    time           wr_t_q[$];
    logic [AW-1:0] rd_addr_q[$];
    time           rd_t_q[$];
    int            wr_long = 0;
    logic          wr_prev = 1'b0;
    logic          rd_pend = 1'b0;
    logic [W-1:0]  rd_word = '0;

    // rd_data is only meaningful in the single cycle after rd_req; garbage otherwise.
    always @(negedge clk) begin
        if (bus.wr_assert) begin
            if (wr_prev) wr_long++;
            else begin
                wr_addr_q.push_back(bus.address);
                wr_data_q.push_back(bus.out_instr);
                wr_t_q.push_back($time);
            end
        end
        wr_prev = bus.wr_assert;
        if (bus.rd_req) begin
            rd_addr_q.push_back(bus.address);
            rd_t_q.push_back($time);
        end
        bus.rd_data = rd_pend ? rd_word : W'($urandom());
        rd_pend = bus.rd_req;
    end

    // Frame-level reference state: what address/out_instr should hold after each frame.
    logic [AW-1:0] m_addr = '0;
    logic [W-1:0]  m_out  = '0;

    task automatic check_all_zero(input string tag);
        check_val({tag, "_miso"},  64'(bus.miso), 64'(0));
        check_val({tag, "_busy"},  64'(bus.busy), 64'(0));
        check_val({tag, "_addr"},  64'(bus.address), 64'(0));
        check_val({tag, "_out"},   64'(bus.out_instr), 64'(0));
        check_val({tag, "_wr"},    64'(bus.wr_assert), 64'(0));
        check_val({tag, "_rd"},    64'(bus.rd_req), 64'(0));
    endtask

    task automatic run_frame(input bit rw, input logic [AW-1:0] addr, input logic [W-1:0] wdata,
                             input logic [W-1:0] rword, input int npulse, input int rst_at,
                             input int gap);
        logic [NBITS-1:0] bits;
        logic [W-1:0]     rx;
        time              t_addr, t_last;
        bit               exp_wr, exp_rd, full;
        bits   = {rw, addr, wdata};
        rx     = '0;
        t_addr = 0;
        t_last = 0;
        rd_word = rword;
        wr_addr_q.delete(); wr_data_q.delete(); wr_t_q.delete();
        rd_addr_q.delete(); rd_t_q.delete();
        wr_long = 0;

        @(negedge clk);
        bus.cs = 1'b0;
        repeat (2) @(negedge clk);
        check_val("busy_before_sync", 64'(bus.busy), 64'(0));
        @(negedge clk);
        check_val("busy_rise", 64'(bus.busy), 64'(1));

        for (int i = 0; i < npulse; i++) begin
            bus.mosi = (i < NBITS) ? bits[NBITS-1-i] : 1'($urandom());
            repeat ($urandom_range(4, 6)) @(negedge clk);
            bus.sclk = 1'b1;
            if (i == AW)       t_addr = $time;
            if (i == NBITS-1)  t_last = $time;
            if (i > AW && i < NBITS) rx = {rx[W-2:0], bus.miso};
            if (i == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                check_all_zero("midreset");
                reset = 1'b0;
            end
            repeat ($urandom_range(4, 6)) @(negedge clk);
            bus.sclk = 1'b0;
        end
        repeat ($urandom_range(4, 6)) @(negedge clk);
        bus.cs = 1'b1;
        repeat (gap) @(negedge clk);

        full   = (npulse >= NBITS) && (rst_at < 0);
        exp_wr = !rw && full;
        exp_rd = rw && (npulse > AW) && (rst_at < 0 || rst_at > AW + 1);
        if (npulse > AW && (rst_at < 0 || rst_at > AW + 1)) m_addr = addr;
        if (exp_wr) m_out = wdata;
        if (rst_at >= 0) begin
            m_addr = '0;
            m_out  = '0;
        end

        check_val("wr_count", 64'(wr_addr_q.size()), 64'(exp_wr));
        check_val("wr_width", 64'(wr_long), 64'(0));
        if (exp_wr && wr_addr_q.size() == 1) begin
            check_val("wr_addr", 64'(wr_addr_q[0]), 64'(addr));
            check_val("wr_data", 64'(wr_data_q[0]), 64'(wdata));
            check_val("wr_latency", 64'(wr_t_q[0] - t_last), 64'(4 * CLK_P));
        end
        check_val("rd_count", 64'(rd_addr_q.size()), 64'(exp_rd));
        if (exp_rd && rd_addr_q.size() == 1) begin
            check_val("rd_addr", 64'(rd_addr_q[0]), 64'(addr));
            check_val("rd_latency", 64'(rd_t_q[0] - t_addr), 64'(4 * CLK_P));
        end
        check_val("address_after", 64'(bus.address), 64'(m_addr));
        check_val("out_instr_after", 64'(bus.out_instr), 64'(m_out));
        check_val("busy_after", 64'(bus.busy), 64'(0));
        if (rw && full) check_val("miso_stream", 64'(rx), 64'(rword));
        else if (!full) check_val("miso_abort", 64'(bus.miso), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected completion first");
        $fatal(1);
    end

    initial begin
        bus.cs   = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        run_frame(1'b0, 8'h2A, 32'hDEADBEEF, 32'h0, NBITS, -1, 6);
        run_frame(1'b1, 8'h05, W'($urandom()), 32'h12345678, NBITS, -1, 6);
        run_frame(1'b0, 8'h05, 32'h0BADF00D, 32'h0, 20, -1, 6);
        run_frame(1'b0, 8'h01, 32'hA5A5A5A5, 32'h0, NBITS, -1, 6);
        run_frame(1'b0, AW'($urandom()), W'($urandom()), 32'h0, 45, -1, 6);
        run_frame(1'b1, AW'($urandom()), W'($urandom()), W'($urandom()), NBITS, 25, 6);
        run_frame(1'b1, 8'h10, W'($urandom()), W'($urandom()), NBITS, -1, 6);
        run_frame(1'b0, 8'h03, 32'h00000001, 32'h0, NBITS, -1, 4);
        run_frame(1'b1, 8'h03, W'($urandom()), W'($urandom()), NBITS, -1, 4);

        for (int k = 0; k < 10; k++) begin
            int np;
            np = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NBITS - 1)) : NBITS;
            run_frame(1'($urandom()), AW'($urandom()), W'($urandom()), W'($urandom()),
                      np, -1, int'($urandom_range(4, 8)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
